// File: rtl/vaccine_pkg.sv
// vaccine_pkg: shared state encoding and ID constants for the check-in desk and little_east
package vaccine_pkg;
  typedef enum logic [1:0] {OPEN = 2'd0, DRAINING = 2'd1, CLOSED = 2'd2} state_t;
  localparam int BUBBLE_ID = 0;
  localparam int PERSON_ID_W = 32;
endpackage

// File: rtl/checkin_fifo.sv
// checkin_fifo: synchronous FIFO with registered storage read at the head pointer and an occupancy count
module checkin_fifo
  import vaccine_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W = PERSON_ID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ID_W-1:0]          push_data,
  input  logic                     pop,
  output logic [ID_W-1:0]          head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [ID_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end
  assign head = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/vaccine_checkin.sv
// vaccine_checkin: arrival FIFO with open/draining/closed control feeding little_east one ID per clock
module vaccine_checkin
  import vaccine_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W = PERSON_ID_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arrive_valid,
  input  logic [ID_W-1:0]        arrive_id,
  output logic                   arrive_ready,
  input  logic                   issue_en,
  output logic [ID_W-1:0]        person_id,
  output logic                   person_valid,
  input  logic                   close,
  input  logic                   open,
  output logic                   closed,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [CNT_W-1:0]       rejected_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  logic [ID_W-1:0] person_id_q, person_id_d, head;
  logic person_valid_q, person_valid_d;
  logic [CNT_W-1:0] issued_q, issued_d, rejected_q, rejected_d;
  logic accept, reject, pop;
  checkin_fifo #(.DEPTH(DEPTH), .ID_W(ID_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .push_data(arrive_id),
    .pop(pop),
    .head(head),
    .count(queue_count)
  );
  // ready looks only at registered state so it never races issue_en
  assign arrive_ready = !rst && state_q == OPEN && queue_count < CW'(DEPTH);
  always_comb begin
    accept = arrive_valid && arrive_ready && arrive_id != ID_W'(BUBBLE_ID);
    reject = arrive_valid && arrive_ready && arrive_id == ID_W'(BUBBLE_ID);
    pop = issue_en && queue_count != '0 && state_q != CLOSED;
    state_d = state_q == OPEN && close ? DRAINING :
              state_q == DRAINING && queue_count == '0 ? CLOSED :
              state_q == CLOSED && open ? OPEN : state_q;
    person_id_d = pop ? head : ID_W'(BUBBLE_ID);
    person_valid_d = pop;
    issued_d = pop && !(&issued_q) ? issued_q + 1'b1 : issued_q;
    rejected_d = reject && !(&rejected_q) ? rejected_q + 1'b1 : rejected_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OPEN;
      person_id_q <= '0;
      person_valid_q <= 1'b0;
      issued_q <= '0;
      rejected_q <= '0;
    end else begin
      state_q <= state_d;
      person_id_q <= person_id_d;
      person_valid_q <= person_valid_d;
      issued_q <= issued_d;
      rejected_q <= rejected_d;
    end
  end
  assign person_id = person_id_q;
  assign person_valid = person_valid_q;
  assign closed = state_q == CLOSED;
  assign issued_cnt = issued_q;
  assign rejected_cnt = rejected_q;
endmodule

// File: tb/tb_vaccine_checkin.sv
// tb_vaccine_checkin: directed scenarios with an expected-ID scoreboard checked on every clock
module tb_vaccine_checkin;
  logic clk = 0, rst = 1;
  logic arrive_valid = 0, issue_en = 0, close = 0, open = 0;
  logic [31:0] arrive_id = 0;
  logic arrive_ready, person_valid, closed;
  logic [31:0] person_id;
  logic [3:0] queue_count;
  logic [15:0] issued_cnt, rejected_cnt;
  int n_vec = 0, n_err = 0;
  logic [31:0] sb[$];

  vaccine_checkin dut (
    .clk(clk), .rst(rst), .arrive_valid(arrive_valid), .arrive_id(arrive_id),
    .arrive_ready(arrive_ready), .issue_en(issue_en), .person_id(person_id),
    .person_valid(person_valid), .close(close), .open(open), .closed(closed),
    .queue_count(queue_count), .issued_cnt(issued_cnt), .rejected_cnt(rejected_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic ev);
    @(posedge clk);
    #1;
    chk("person_valid", person_valid, ev);
    if (person_valid) begin
      if (sb.size() == 0) chk("unexpected_issue", person_id, 0);
      else chk("person_id", person_id, sb.pop_front());
    end else chk("bubble", person_id, 0);
  endtask

  task automatic drive(input logic v, input logic [31:0] id);
    arrive_valid = v;
    arrive_id = id;
    if (v && id != 0) sb.push_back(id);
  endtask

  initial begin
    #3;
    chk("rst_person_id", person_id, 0);
    chk("rst_valid", person_valid, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_rejected", rejected_cnt, 0);
    chk("rst_closed", closed, 0);
    #10 rst = 0;
    #1 chk("ready_after_rst", arrive_ready, 1);
    // burst in order
    issue_en = 1;
    drive(1, 123); tick(0);
    drive(1, 47);  tick(1);
    drive(1, 59);  tick(1);
    drive(1, 92);  tick(1);
    drive(0, 0);   tick(1);
    tick(0);
    chk("burst_issued", issued_cnt, 4);
    chk("burst_count", queue_count, 0);
    // fill and backpressure
    issue_en = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1, i); tick(0);
    end
    chk("full_ready", arrive_ready, 0);
    chk("full_count", queue_count, 8);
    drive(1, 9); tick(0);
    chk("stall_ready", arrive_ready, 0);
    chk("stall_count", queue_count, 8);
    issue_en = 1;
    tick(1);
    chk("ready_after_pop", arrive_ready, 1);
    chk("count_after_pop", queue_count, 7);
    tick(1);
    drive(0, 0);
    chk("count_9_in", queue_count, 7);
    for (int i = 0; i < 7; i++) tick(1);
    tick(0);
    chk("fill_rejected", rejected_cnt, 0);
    chk("fill_issued", issued_cnt, 13);
    // zero ID
    drive(1, 0); tick(0);
    drive(0, 0);
    chk("zero_rejected", rejected_cnt, 1);
    chk("zero_count", queue_count, 0);
    tick(0);
    // close and drain
    issue_en = 0;
    drive(1, 5); tick(0);
    drive(1, 6); tick(0);
    drive(1, 7); tick(0);
    drive(0, 0);
    issue_en = 1; close = 1;
    tick(1);
    close = 0;
    chk("drain_ready", arrive_ready, 0);
    chk("drain_closed", closed, 0);
    tick(1);
    tick(1);
    chk("last_pop_closed", closed, 0);
    tick(0);
    chk("closed_flag", closed, 1);
    chk("closed_ready", arrive_ready, 0);
    arrive_valid = 1; arrive_id = 77;
    tick(0);
    chk("closed_stall_rej", rejected_cnt, 1);
    chk("closed_stall_cnt", queue_count, 0);
    open = 1;
    tick(0);
    open = 0;
    chk("reopen_ready", arrive_ready, 1);
    chk("reopen_closed", closed, 0);
    sb.push_back(77);
    tick(0);
    drive(0, 0);
    tick(1);
    chk("drain_issued", issued_cnt, 17);
    // simultaneous push and pop
    issue_en = 0;
    drive(1, 10); tick(0);
    drive(1, 11); tick(0);
    chk("sim_count_pre", queue_count, 2);
    issue_en = 1;
    drive(1, 92); tick(1);
    drive(0, 0);
    chk("sim_count", queue_count, 2);
    tick(1); tick(1); tick(0);
    chk("sim_issued", issued_cnt, 20);
    // reset mid-operation
    issue_en = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(1, i); tick(0);
    end
    drive(0, 0);
    issue_en = 1;
    tick(1);
    issue_en = 0;
    chk("pre_rst_count", queue_count, 5);
    #1 rst = 1;
    #1;
    chk("mid_rst_person_id", person_id, 0);
    chk("mid_rst_valid", person_valid, 0);
    chk("mid_rst_count", queue_count, 0);
    chk("mid_rst_issued", issued_cnt, 0);
    chk("mid_rst_rejected", rejected_cnt, 0);
    sb.delete();
    #2 rst = 0;
    tick(0);
    chk("post_rst_ready", arrive_ready, 1);
    chk("post_rst_count", queue_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
